univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 144 ++++++++++++++
 tb/tb_univ_shift_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with a single-step mode and a
// counted burst engine.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   en         clock enable; low freezes q, the FSM and the counter
//   mode[2:0]  operation select (hold/shift/rotate/load/clear)
//   sin_lo     serial in entering q[0] on a shift up
//   sin_hi     serial in entering q[WIDTH-1] on a shift down
//   pdata      parallel load data
//   start      burst request (only for shift/rotate modes, only in IDLE)
//   burst_len  number of burst steps
//   q          register contents
//   sout_lo    q[0]
//   sout_hi    q[WIDTH-1]
//   busy       high while a burst is running
//   done       one-cycle pulse after the final burst step
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_lo,
  input  logic             sin_hi,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             sout_lo,
  output logic             sout_hi,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SHUP  = 3'b001;
  localparam logic [2:0] OP_SHDN  = 3'b010;
  localparam logic [2:0] OP_ROTUP = 3'b011;
  localparam logic [2:0] OP_ROTDN = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_done;

  logic             w_burst_req;
  logic [2:0]       w_step_op;
  logic [WIDTH-1:0] w_q_next;

  // One register operation; shared by single-step and burst paths.
  function automatic logic [WIDTH-1:0] f_step(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sl,
    input logic             sh,
    input logic [WIDTH-1:0] pd
  );
    logic [WIDTH-1:0] nxt;
    case (op)
      OP_SHUP:  nxt = {cur[WIDTH-2:0], sl};
      OP_SHDN:  nxt = {sh, cur[WIDTH-1:1]};
      OP_ROTUP: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROTDN: nxt = {cur[0], cur[WIDTH-1:1]};
      OP_LOAD:  nxt = pd;
      OP_CLR:   nxt = {WIDTH{1'b0}};
      OP_HOLD:  nxt = cur;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

  // Only the four shift/rotate modes can launch a burst; any other mode
  // with start=1 falls through to a plain single step.
  assign w_burst_req = start && (mode inside {OP_SHUP, OP_SHDN, OP_ROTUP, OP_ROTDN});
  // While busy the latched burst op drives the datapath and mode is ignored.
  assign w_step_op   = (r_state == S_BUSY) ? r_op : mode;
  assign w_q_next    = f_step(w_step_op, r_q, sin_lo, sin_hi, pdata);

  // Register, burst FSM and counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= {WIDTH{1'b0}};
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_op    <= OP_HOLD;
      r_done  <= 1'b0;
    end else begin
      // done is a pulse: it drops on the next edge even if en is low.
      r_done <= 1'b0;
      if (en) begin
        case (r_state)
          S_IDLE: begin
            if (w_burst_req) begin
              // The start cycle only arms the burst; q is untouched.
              r_op  <= mode;
              r_cnt <= burst_len;
              if (burst_len != {CNT_W{1'b0}}) begin
                r_state <= S_BUSY;
              end else begin
                r_done <= 1'b1;
              end
            end else begin
              r_q <= w_q_next;
            end
          end
          S_BUSY: begin
            r_q   <= w_q_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign q       = r_q;
  assign sout_lo = r_q[0];
  assign sout_hi = r_q[WIDTH-1];
  assign busy    = (r_state == S_BUSY);
  assign done    = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios followed by a
// randomized run, all compared against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam longint unsigned MODV = 64'd1 << WIDTH;
  localparam longint unsigned TOPV = MODV / 64'd2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic             sin_lo;
  logic             sin_hi;
  logic [WIDTH-1:0] pdata;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  wire  [WIDTH-1:0] q;
  wire              sout_lo;
  wire              sout_hi;
  wire              busy;
  wire              done;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  longint unsigned m_q    = 0;
  bit              m_busy = 1'b0;
  bit              m_done = 1'b0;
  int              m_cnt  = 0;
  int              m_op   = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_lo(sin_lo),
    .sin_hi(sin_hi), .pdata(pdata), .start(start), .burst_len(burst_len),
    .q(q), .sout_lo(sout_lo), .sout_hi(sout_hi), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Operations expressed as plain arithmetic on the register value.
  function automatic longint unsigned model_op(input int op, input longint unsigned v,
                                               input bit sl, input bit sh,
                                               input longint unsigned pd);
    case (op)
      1: return (v * 2 + sl) % MODV;
      2: return v / 2 + (sh ? TOPV : 0);
      3: return (v * 2) % MODV + v / TOPV;
      4: return v / 2 + (v % 2) * TOPV;
      5: return pd % MODV;
      6: return 0;
      default: return v;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare all outputs.
  task automatic cycle(input bit r, input bit e, input int md, input bit st,
                       input int bl, input bit sl, input bit sh, input int pd);
    rst = r; en = e; mode = 3'(md); start = st; burst_len = CNT_W'(bl);
    sin_lo = sl; sin_hi = sh; pdata = WIDTH'(pd);
    @(posedge clk);
    if (r) begin
      m_q = 0; m_busy = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (e) begin
        if (m_busy) begin
          m_q = model_op(m_op, m_q, sl, sh, 0);
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end else if (st && md >= 1 && md <= 4) begin
          m_op = md;
          m_cnt = bl;
          if (bl != 0) m_busy = 1;
          else m_done = 1;
        end else begin
          m_q = model_op(md, m_q, sl, sh, longint'(pd));
        end
      end
    end
    #1;
    chk("q", q, m_q);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("sout_lo", sout_lo, m_q % 2);
    chk("sout_hi", sout_hi, m_q / TOPV);
  endtask

  task automatic op1(input int md, input bit sl, input bit sh, input int pd);
    cycle(1'b0, 1'b1, md, 1'b0, 0, sl, sh, pd);
  endtask

  initial begin
    int busy_cycles;

    // Reset state.
    cycle(1'b1, 1'b0, 5, 1'b1, 3, 1'b1, 1'b1, 'hFF);
    chk("reset_q", q, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // Load then shift up.
    op1(5, 1'b0, 1'b0, 'hA5);
    op1(1, 1'b1, 1'b0, 0);
    chk("load_shup_q", q, 'h4B);
    chk("load_shup_sout_hi", sout_hi, 0);

    // Shift down x8 with sin_hi=1 from zero.
    op1(6, 1'b0, 1'b0, 0);
    op1(2, 1'b0, 1'b1, 0);
    chk("shdn_first_q", q, 'h80);
    for (int i = 0; i < 7; i++) op1(2, 1'b0, 1'b1, 0);
    chk("shdn_all_q", q, 'hFF);

    // Rotate-up burst of 3 from 0x81.
    op1(5, 1'b0, 1'b0, 'h81);
    cycle(1'b0, 1'b1, 3, 1'b1, 3, 1'b0, 1'b0, 0);
    chk("rot_start_q", q, 'h81);
    busy_cycles = 0;
    if (busy) busy_cycles++;
    for (int i = 0; i < 3; i++) begin
      op1(0, 1'b0, 1'b0, 0);
      if (busy) busy_cycles++;
    end
    chk("rot_busy_cycles", busy_cycles, 3);
    chk("rot_done_4th", done, 1);
    chk("rot_q", q, 'h0C);
    op1(0, 1'b0, 1'b0, 0);
    chk("rot_done_pulse", done, 0);

    // Paused shift-down burst of 2; mode/start/pdata noise is ignored.
    op1(5, 1'b0, 1'b0, 'hC3);
    cycle(1'b0, 1'b1, 2, 1'b1, 2, 1'b0, 1'b0, 0);
    busy_cycles = busy ? 1 : 0;
    cycle(1'b0, 1'b1, 5, 1'b1, 7, 1'b1, 1'b0, 'h11);
    if (busy) busy_cycles++;
    cycle(1'b0, 1'b0, 6, 1'b0, 0, 1'b0, 1'b0, 0);
    if (busy) busy_cycles++;
    cycle(1'b0, 1'b0, 6, 1'b0, 0, 1'b0, 1'b0, 0);
    if (busy) busy_cycles++;
    cycle(1'b0, 1'b1, 1, 1'b0, 0, 1'b1, 1'b0, 0);
    if (busy) busy_cycles++;
    chk("pause_busy_cycles", busy_cycles, 4);
    chk("pause_q", q, 'h30);
    chk("pause_done", done, 1);

    // Zero-length burst, then start with an illegal (load) mode.
    cycle(1'b0, 1'b1, 1, 1'b1, 0, 1'b1, 1'b1, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_q", q, 'h30);
    cycle(1'b0, 1'b1, 5, 1'b1, 3, 1'b0, 1'b0, 'h5A);
    chk("illegal_start_q", q, 'h5A);
    chk("illegal_start_busy", busy, 0);

    // Reset during the second BUSY cycle, then a normal burst.
    cycle(1'b0, 1'b1, 1, 1'b1, 4, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 0);
    chk("rst_mid_q", q, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    op1(0, 1'b0, 1'b0, 0);
    chk("rst_mid_no_done", done, 0);
    op1(5, 1'b0, 1'b0, 'h01);
    cycle(1'b0, 1'b1, 4, 1'b1, 2, 1'b0, 1'b0, 0);
    op1(0, 1'b0, 1'b0, 0);
    op1(0, 1'b0, 1'b0, 0);
    chk("post_rst_burst_q", q, 'h40);
    chk("post_rst_burst_done", done, 1);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 255)));
      chk("busy_done_exclusive", busy & done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
